minefield_engine: RTL and testbench

Parametrised minesweeper board generator, the next generation of the fixed 8×8 board top. On `start` it clears an R×C board, places a requested number of mines at pseudo-random distinct cells drawn from a seeded LFSR, then computes every cell's adjacent-mine count. The board is held for the display/game logic through a registered read port. It replaces the hard-wired matrix plus adjacency pair with one self-sequencing block.

---
 rtl/minefield_pkg.sv | 24 ++
 rtl/minefield_engine_if.sv | 27 ++
 rtl/minefield_lfsr.sv | 23 ++
 rtl/minefield_engine.sv | 166 ++++++++++++++++
 tb/tb_minefield_engine.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minefield_pkg.sv
// Shared types and constants for the minesweeper board generator.
package minefield_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      PLACE,
      COUNT,
      DONE
   } state_t;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   typedef struct packed {
      logic       mine;
      logic [3:0] count;
   } cell_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/minefield_engine_if.sv
// Control, parameter and read-port signals of the board generator.
interface minefield_engine_if #(
   parameter int NB_W = 8
);
   logic            start;
   logic [15:0]     seed;
   logic [NB_W-1:0] num_bombs;
   logic [3:0]      safe_row;
   logic [3:0]      safe_col;
   logic [3:0]      rd_row;
   logic [3:0]      rd_col;
   logic            rd_mine;
   logic [3:0]      rd_count;
   logic [NB_W-1:0] mines_placed;
   logic            busy;
   logic            done;

   modport master (
      output start, seed, num_bombs, safe_row, safe_col, rd_row, rd_col,
      input  rd_mine, rd_count, mines_placed, busy, done
   );

   modport slave (
      input  start, seed, num_bombs, safe_row, safe_col, rd_row, rd_col,
      output rd_mine, rd_count, mines_placed, busy, done
   );
endinterface

// File: rtl/minefield_lfsr.sv
// 16-bit Galois LFSR; load replaces a zero seed with the default, step advances one state.
module minefield_lfsr
   import minefield_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= LFSR_DEFAULT;
      end else if (load) begin
         state <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/minefield_engine.sv
// Board generator: CLEAR(1) + PLACE(data-dependent) + COUNT(ROWS*COLS) cycles; start ignored while busy.
// Registered read port, 1-cycle latency. MINEFIELD_SAFE_FIRST_EN keeps one captured cell mine-free.
module minefield_engine
   import minefield_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int NB_W = 8
)
(
   input logic               clk,
   input logic               reset,
   minefield_engine_if.slave bus
);

   localparam int CELLS = ROWS * COLS;
   localparam int IDX_W = $clog2(CELLS);
`ifdef MINEFIELD_SAFE_FIRST_EN
   localparam int MAX_BOMBS = CELLS - 2;
`else
   localparam int MAX_BOMBS = CELLS - 1;
`endif

   state_t          state_q, state_d;
   cell_t           board_q [CELLS];
   logic [NB_W-1:0] req_q, placed_q, req_clamped;
   logic [3:0]      row_q, col_q;
   logic [15:0]     lfsr_q;
   logic            lfsr_load, lfsr_step;
   logic [IDX_W-1:0] cand, cnt_idx, rd_idx;
   logic            cand_ok, place_hit, last_cell, rd_in, safe_hit;
   logic [3:0]      nb_sum;
   int              nr, nc;
   logic            unused_lfsr;

   minefield_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .seed  (bus.seed),
      .step  (lfsr_step),
      .state (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[15:IDX_W];

`ifdef MINEFIELD_SAFE_FIRST_EN
   logic             safe_vld_q;
   logic [IDX_W-1:0] safe_idx_q;

   // An off-board safe cell simply never matches a candidate.
   always_ff @(posedge clk) begin
      if (!reset) begin
         safe_vld_q <= 1'b0;
         safe_idx_q <= '0;
      end else if (state_q == IDLE && bus.start) begin
         safe_vld_q <= (int'(bus.safe_row) < ROWS) && (int'(bus.safe_col) < COLS);
         safe_idx_q <= IDX_W'(int'(bus.safe_row) * COLS + int'(bus.safe_col));
      end
   end

   assign safe_hit = safe_vld_q && (cand == safe_idx_q);
`else
   logic unused_safe;
   assign unused_safe = ^{bus.safe_row, bus.safe_col};
   assign safe_hit    = 1'b0;
`endif

   assign req_clamped = (int'(bus.num_bombs) > MAX_BOMBS) ? NB_W'(MAX_BOMBS) : bus.num_bombs;
   assign cand        = lfsr_q[IDX_W-1:0];
   assign cand_ok     = ({1'b0, cand} < (IDX_W+1)'(CELLS)) && !board_q[cand].mine && !safe_hit;
   assign place_hit   = (state_q == PLACE) && cand_ok;
   assign last_cell   = (int'(row_q) == ROWS - 1) && (int'(col_q) == COLS - 1);
   assign cnt_idx     = IDX_W'(int'(row_q) * COLS + int'(col_q));
   assign rd_in       = (int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS);
   assign rd_idx      = IDX_W'(int'(bus.rd_row) * COLS + int'(bus.rd_col));
   assign bus.mines_placed = placed_q;

   always_comb begin
      nb_sum = '0;
      nr     = 0;
      nc     = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            nr = int'(row_q) + dr;
            nc = int'(col_q) + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
               nb_sum = nb_sum + {3'b000, board_q[IDX_W'(nr * COLS + nc)].mine};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CLEAR;
         CLEAR:   state_d = (req_q == '0) ? COUNT : PLACE;
         PLACE:   if (place_hit && (placed_q + NB_W'(1)) == req_q) state_d = COUNT;
         COUNT:   if (last_cell) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state_q)
         IDLE:    lfsr_load = bus.start;
         CLEAR:   bus.busy  = 1'b1;
         PLACE: begin
            bus.busy  = 1'b1;
            lfsr_step = 1'b1;
         end
         COUNT:   bus.busy  = 1'b1;
         default: bus.done  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < CELLS; i++) board_q[i] <= '0;
         req_q        <= '0;
         placed_q     <= '0;
         row_q        <= '0;
         col_q        <= '0;
         bus.rd_mine  <= 1'b0;
         bus.rd_count <= '0;
      end else begin
         bus.rd_mine  <= rd_in ? board_q[rd_idx].mine  : 1'b0;
         bus.rd_count <= rd_in ? board_q[rd_idx].count : 4'd0;
         case (state_q)
            IDLE: if (bus.start) req_q <= req_clamped;
            CLEAR: begin
               for (int i = 0; i < CELLS; i++) board_q[i] <= '0;
               placed_q <= '0;
               row_q    <= '0;
               col_q    <= '0;
            end
            PLACE: if (place_hit) begin
               board_q[cand].mine <= 1'b1;
               placed_q           <= placed_q + NB_W'(1);
            end
            COUNT: begin
               // Mine cells get a count too; the game logic decides what to show.
               board_q[cnt_idx].count <= nb_sum;
               if (int'(col_q) == COLS - 1) begin
                  col_q <= '0;
                  row_q <= row_q + 4'd1;
               end else begin
                  col_q <= col_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_minefield_engine.sv
// Directed bench for an 8x8 and a 4x6 generator fed from shared stimulus; board contents come from a placement model.
module tb_minefield_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [7:0]  num_bombs = 8'd0;
   logic [3:0]  safe_r = 4'd15;
   logic [3:0]  safe_c = 4'd15;
   logic [3:0]  rd_r = 4'd0;
   logic [3:0]  rd_c = 4'd0;
   int          sel = 0;

   logic        o_busy, o_done, o_rd_mine;
   logic [3:0]  o_rd_count;
   logic [7:0]  o_placed;

   typedef struct {
      int r;
      int c;
      int m;
      int n;
   } rd_exp_t;

   rd_exp_t sbq[$];
   int      n_vec = 0;
   int      n_miss = 0;
   bit      exp_mine [256];
   int      exp_placed, exp_p, mine_total;

   always #5 clk = ~clk;

   minefield_engine_if #(.NB_W(8)) bus8 ();
   minefield_engine_if #(.NB_W(8)) bus46 ();

   assign bus8.start     = start;
   assign bus8.seed      = seed;
   assign bus8.num_bombs = num_bombs;
   assign bus8.safe_row  = safe_r;
   assign bus8.safe_col  = safe_c;
   assign bus8.rd_row    = rd_r;
   assign bus8.rd_col    = rd_c;
   assign bus46.start     = start;
   assign bus46.seed      = seed;
   assign bus46.num_bombs = num_bombs;
   assign bus46.safe_row  = safe_r;
   assign bus46.safe_col  = safe_c;
   assign bus46.rd_row    = rd_r;
   assign bus46.rd_col    = rd_c;

   minefield_engine #(.ROWS(8), .COLS(8), .NB_W(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   minefield_engine #(.ROWS(4), .COLS(6), .NB_W(8)) dut46 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus46.slave)
   );

   always_comb begin
      if (sel == 1) begin
         o_busy = bus46.busy;  o_done = bus46.done;  o_rd_mine = bus46.rd_mine;
         o_rd_count = bus46.rd_count;  o_placed = bus46.mines_placed;
      end else begin
         o_busy = bus8.busy;  o_done = bus8.done;  o_rd_mine = bus8.rd_mine;
         o_rd_count = bus8.rd_count;  o_placed = bus8.mines_placed;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Independent placement model: Galois LFSR, candidate from the pre-step state.
   task automatic model_gen(input int rows, input int cols, input logic [15:0] sd, input int nb);
      int cells, lim, req, ib, cand, sidx;
      bit sfe;
      logic [15:0] l;
      cells = rows * cols;
      for (int i = 0; i < 256; i++) exp_mine[i] = 1'b0;
      lim  = cells - 1;
      sfe  = 1'b0;
      sidx = 0;
`ifdef MINEFIELD_SAFE_FIRST_EN
      lim  = cells - 2;
      sfe  = (int'(safe_r) < rows) && (int'(safe_c) < cols);
      sidx = int'(safe_r) * cols + int'(safe_c);
`endif
      req = (nb > lim) ? lim : nb;
      ib = 0;
      while ((1 << ib) < cells) ib++;
      l = (sd == 16'h0000) ? 16'hACE1 : sd;
      exp_placed = 0;
      exp_p = 0;
      while (exp_placed < req && exp_p < 100000) begin
         exp_p++;
         cand = int'(l) & ((1 << ib) - 1);
         if (cand < cells && !exp_mine[cand] && !(sfe && cand == sidx)) begin
            exp_mine[cand] = 1'b1;
            exp_placed++;
         end
         l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
   endtask

   function automatic int model_count(input int rows, input int cols, input int r, input int c);
      int s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < rows && c + dc >= 0 && c + dc < cols)
               s += int'(exp_mine[(r + dr) * cols + (c + dc)]);
      return s;
   endfunction

   task automatic wait_idle();
      int g = 0;
      while ((bus8.busy || bus8.done || bus46.busy || bus46.done) && g < 30000) begin
         @(negedge clk);
         g++;
      end
      check("idle_reached", 32'(g < 30000), 32'd1);
   endtask

   task automatic rd_retire();
      rd_exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check($sformatf("rd_mine_r%0dc%0d", e.r, e.c), 32'(o_rd_mine), 32'(e.m));
         check($sformatf("rd_count_r%0dc%0d", e.r, e.c), 32'(o_rd_count), 32'(e.n));
         mine_total += int'(o_rd_mine);
      end
   endtask

   task automatic rd_issue(input int r, input int c, input int m, input int n);
      rd_exp_t e;
      rd_retire();
      rd_r = 4'(r);
      rd_c = 4'(c);
      e = '{r, c, m, n};
      sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic read_all(input int rows, input int cols, input string tag);
      mine_total = 0;
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++)
            rd_issue(r, c, int'(exp_mine[r * cols + c]), model_count(rows, cols, r, c));
      rd_retire();
      check({tag, "_mine_total"}, 32'(mine_total), 32'(exp_placed));
   endtask

   task automatic run_gen(input logic [15:0] sd, input int nb, input int rows, input int cols,
                          input string tag);
      int cycles = 0;
      int guard = 0;
      wait_idle();
      model_gen(rows, cols, sd, nb);
      check({tag, "_busy_idle"}, 32'(o_busy), 32'd0);
      seed = sd;
      num_bombs = 8'(nb);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
      while (o_done !== 1'b1 && guard < 20000) begin
         if (o_busy) cycles++;
         @(negedge clk);
         guard++;
      end
      check({tag, "_done_seen"}, 32'(o_done), 32'd1);
      check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
      check({tag, "_latency"}, 32'(cycles), 32'(1 + exp_p + rows * cols));
      check({tag, "_mines_placed"}, 32'(o_placed), 32'(exp_placed));
   endtask

   initial begin
      int guard;
      bit done_seen;

      // Reset state of both instances
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         check($sformatf("rst_busy_%0d", s), 32'(o_busy), 32'd0);
         check($sformatf("rst_done_%0d", s), 32'(o_done), 32'd0);
         check($sformatf("rst_rd_mine_%0d", s), 32'(o_rd_mine), 32'd0);
         check($sformatf("rst_rd_count_%0d", s), 32'(o_rd_count), 32'd0);
         check($sformatf("rst_placed_%0d", s), 32'(o_placed), 32'd0);
      end
      sel = 0;
      reset = 1'b1;
      @(negedge clk);

      // Empty board, then start in DONE ignored and accepted in the next IDLE
      run_gen(16'h1234, 0, 8, 8, "zero");
      read_all(8, 8, "zero");
      wait_idle();
      run_gen(16'h1234, 0, 8, 8, "zero_b");
      start = 1'b1;
      @(negedge clk);
      check("start_in_done_ignored", 32'(o_busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      check("start_after_done", 32'(o_busy), 32'd1);

      // Ten mines, twice from the same seed
      for (int k = 0; k < 2; k++) begin
         run_gen(16'h1234, 10, 8, 8, $sformatf("ten%0d", k));
         check($sformatf("ten%0d_placed_const", k), 32'(o_placed), 32'd10);
         read_all(8, 8, $sformatf("ten%0d", k));
      end

      // Over-request is clamped; zero seed uses the default
      run_gen(16'h0000, 200, 8, 8, "clamp");
`ifdef MINEFIELD_SAFE_FIRST_EN
      check("clamp_placed_const", 32'(o_placed), 32'd62);
`else
      check("clamp_placed_const", 32'(o_placed), 32'd63);
`endif
      read_all(8, 8, "clamp");

      // Non-square 4x6 board with off-board reads
      sel = 1;
      run_gen(16'h1234, 5, 4, 6, "b46");
      check("b46_placed_const", 32'(o_placed), 32'd5);
      read_all(4, 6, "b46");
      rd_issue(5, 0, 0, 0);
      rd_issue(5, 3, 0, 0);
      rd_issue(2, 6, 0, 0);
      rd_issue(15, 15, 0, 0);
      rd_retire();
      sel = 0;

      // Stray start in PLACE, reset in mid-COUNT
      wait_idle();
      model_gen(8, 8, 16'h5555, 10);
      seed = 16'h5555;
      num_bombs = 8'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("stray_busy", 32'(o_busy), 32'd1);
      repeat (exp_p + 27) @(negedge clk);
      check("midcount_busy", 32'(o_busy), 32'd1);
      check("midcount_placed", 32'(o_placed), 32'(exp_placed));
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_done", 32'(o_done), 32'd0);
      check("abort_rd_mine", 32'(o_rd_mine), 32'd0);
      check("abort_rd_count", 32'(o_rd_count), 32'd0);
      check("abort_placed", 32'(o_placed), 32'd0);
      reset = 1'b1;
      done_seen = 1'b0;
      guard = 0;
      while (guard < 150) begin
         @(negedge clk);
         done_seen |= (o_done === 1'b1);
         guard++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      for (int i = 0; i < 256; i++) exp_mine[i] = 1'b0;
      exp_placed = 0;
      read_all(8, 8, "abort_board");
      run_gen(16'h5555, 10, 8, 8, "regen");
      read_all(8, 8, "regen");

`ifdef MINEFIELD_SAFE_FIRST_EN
      // Protected cell with a near-full board
      safe_r = 4'd3;
      safe_c = 4'd3;
      run_gen(16'h1234, 62, 8, 8, "safe");
      check("safe_placed_const", 32'(o_placed), 32'd62);
      read_all(8, 8, "safe");
      rd_issue(3, 3, 0, 8);
      rd_retire();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
